// File: rtl/data_memory_lsu_if.sv
// Request/response bus between the execute stage and data_memory_lsu.
// master: requester side; slave: memory side.
interface data_memory_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        resp_valid;
  logic [31:0] read_data;
  logic        misaligned;
  logic        out_of_range;
  logic        illegal_size;

  modport master (
    output req_valid, req_write, req_funct3, address, write_data,
    input  req_ready, resp_valid, read_data, misaligned, out_of_range, illegal_size
  );

  modport slave (
    input  req_valid, req_write, req_funct3, address, write_data,
    output req_ready, resp_valid, read_data, misaligned, out_of_range, illegal_size
  );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory with RISC-V load/store sizing, configurable
// response latency and misaligned / out-of-range / illegal-size checks.
// Errored requests respond after one cycle and never touch the array.
module data_memory_lsu #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned ADDR_BITS    = 12,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic              clock,
  input logic              reset,
  data_memory_lsu_if.slave bus
);

  localparam int unsigned IDX_BITS = ADDR_BITS - 2;
  localparam int unsigned CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0]         mem [DEPTH_WORDS];
  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                accept;
  logic [IDX_BITS-1:0] word_idx;
  logic [1:0]          lane;
  logic [31:0]         word_rd;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic                acc_mis, acc_oor, acc_ill, acc_err;
  logic [31:0]         acc_data;
  logic [3:0]          byte_en;
  logic [31:0]         wr_lanes;
  logic [31:0]         hold_data;
  logic [2:0]          hold_flags;
  logic [31:0]         rd_q;
  logic [2:0]          flags_q;

  assign accept     = bus.req_valid && (state == S_IDLE);
  assign word_idx   = bus.address[ADDR_BITS-1:2];
  assign lane       = bus.address[1:0];
  assign word_rd    = mem[word_idx];

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.resp_valid   = (state == S_RESP);
  assign bus.read_data    = rd_q;
  assign bus.misaligned   = flags_q[2];
  assign bus.out_of_range = flags_q[1];
  assign bus.illegal_size = flags_q[0];

  // Error classification straight from the request inputs.
  always_comb begin
    acc_mis = 1'b0;
    case (bus.req_funct3)
      3'b001, 3'b101: acc_mis = lane[0];
      3'b010:         acc_mis = (lane != 2'b00);
      default:        acc_mis = 1'b0;
    endcase
    acc_oor = (bus.address >> ADDR_BITS) != '0;
    acc_ill = (bus.req_funct3 inside {3'b011, 3'b110, 3'b111}) ||
              (bus.req_write && bus.req_funct3[2]);
    acc_err = acc_mis || acc_oor || acc_ill;
  end

  // Little-endian lane extraction with sign/zero extension.
  always_comb begin
    sel_byte = word_rd[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? word_rd[31:16] : word_rd[15:0];
    acc_data = '0;
    if (!bus.req_write && !acc_err) begin
      case (bus.req_funct3)
        3'b000:  acc_data = {{24{sel_byte[7]}}, sel_byte};
        3'b001:  acc_data = {{16{sel_half[15]}}, sel_half};
        3'b010:  acc_data = word_rd;
        3'b100:  acc_data = {24'h0, sel_byte};
        3'b101:  acc_data = {16'h0, sel_half};
        default: acc_data = '0;
      endcase
    end
  end

  // Store byte-lane enables and replicated write data.
  always_comb begin
    byte_en  = '0;
    wr_lanes = '0;
    case (bus.req_funct3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{bus.write_data[15:0]}};
      end
      2'b10: begin
        byte_en  = 4'b1111;
        wr_lanes = bus.write_data;
      end
      default: begin
        byte_en  = '0;
        wr_lanes = '0;
      end
    endcase
  end

  // Store commits on the acceptance edge; array is never reset.
  always_ff @(posedge clock) begin
    if (accept && !reset && bus.req_write && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // Next-state and latency-counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (acc_err || READ_LATENCY == 1) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_next = S_RESP;
        else           cnt_next   = cnt - 1'b1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Load result and flags captured at acceptance for the delayed response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_data  <= '0;
      hold_flags <= '0;
    end else if (accept) begin
      hold_data  <= acc_data;
      hold_flags <= {acc_mis, acc_oor, acc_ill};
    end
  end

  // Registered response outputs, non-zero only during RESP. With a
  // one-cycle path RESP follows IDLE directly, so the live decode is used
  // instead of the held copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      flags_q <= '0;
    end else if (state_next == S_RESP) begin
      rd_q    <= (state == S_IDLE) ? acc_data : hold_data;
      flags_q <= (state == S_IDLE) ? {acc_mis, acc_oor, acc_ill} : hold_flags;
    end else begin
      rd_q    <= '0;
      flags_q <= '0;
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: two instances (latency 1 and 4) driven with the
// same requests and checked against a byte-array reference model.
module tb_data_memory_lsu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [7:0] mem_m [4096];

  data_memory_lsu_if bus1 ();
  data_memory_lsu_if bus4 ();

  assign bus1.req_valid  = req_valid;
  assign bus1.req_write  = req_write;
  assign bus1.req_funct3 = req_funct3;
  assign bus1.address    = address;
  assign bus1.write_data = write_data;
  assign bus4.req_valid  = req_valid;
  assign bus4.req_write  = req_write;
  assign bus4.req_funct3 = req_funct3;
  assign bus4.address    = address;
  assign bus4.write_data = write_data;

  data_memory_lsu #(.DEPTH_WORDS(1024), .ADDR_BITS(12), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));
  data_memory_lsu #(.DEPTH_WORDS(1024), .ADDR_BITS(12), .READ_LATENCY(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: flags from the size/alignment rules, data from a byte array.
  task automatic model_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic [2:0] fl);
    logic mis, oor, ill;
    int unsigned n;
    logic [31:0] v;
    logic [11:0] bi;
    oor = (a >= 32'd4096);
    mis = ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
    ill = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) || (wr && f3[2]);
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    rd = '0;
    fl = {mis, oor, ill};
    if (!(mis || oor || ill)) begin
      if (wr) begin
        for (int unsigned i = 0; i < n; i++) begin
          bi = a[11:0] + 12'(i);
          mem_m[bi] = wd[8*i +: 8];
        end
      end else begin
        v = '0;
        for (int unsigned i = 0; i < n; i++) begin
          bi = a[11:0] + 12'(i);
          v = v | (32'(mem_m[bi]) << (8*i));
        end
        if (!f3[2]) begin
          if (n == 1 && v[7])  v = v | 32'hFFFF_FF00;
          if (n == 2 && v[15]) v = v | 32'hFFFF_0000;
        end
        rd = v;
      end
    end
  endtask

  task automatic observe(input string nm, input int unsigned k, input int unsigned lat,
                         input logic rv, input logic rdy, input logic [31:0] rd,
                         input logic [2:0] fl, input logic [31:0] erd, input logic [2:0] efl);
    chk({nm, ".resp_valid"}, 32'(rv), 32'(k == lat));
    chk({nm, ".req_ready"}, 32'(rdy), 32'(k > lat));
    chk({nm, ".read_data"}, rd, (k == lat) ? erd : 32'h0);
    chk({nm, ".flags"}, 32'(fl), (k == lat) ? 32'(efl) : 32'h0);
  endtask

  // One request to both instances; every cycle of the response window checked.
  task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got1,
                        output logic [31:0] got4, output logic [2:0] fl4);
    logic [31:0] erd;
    logic [2:0]  efl;
    int unsigned lat4;
    model_op(wr, f3, a, wd, erd, efl);
    lat4 = (efl != 3'b000) ? 1 : 4;
    got1 = 'x;
    got4 = 'x;
    fl4  = 'x;
    req_write  = wr;
    req_funct3 = f3;
    address    = a;
    write_data = wd;
    req_valid  = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      observe("rl1", k, 1, bus1.resp_valid, bus1.req_ready, bus1.read_data,
              {bus1.misaligned, bus1.out_of_range, bus1.illegal_size}, erd, efl);
      observe("rl4", k, lat4, bus4.resp_valid, bus4.req_ready, bus4.read_data,
              {bus4.misaligned, bus4.out_of_range, bus4.illegal_size}, erd, efl);
      if (k == 1) got1 = bus1.read_data;
      if (k == lat4) begin
        got4 = bus4.read_data;
        fl4  = {bus4.misaligned, bus4.out_of_range, bus4.illegal_size};
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] g1, g4, erd, prior;
    logic [2:0]  f4, efl;
    logic [2:0]  f3_tab [5];
    logic [2:0]  f3;
    logic [31:0] a;
    int unsigned sel;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    repeat (2) @(posedge clock);
    #1;
    chk("rst.rl1.ready", 32'(bus1.req_ready), 32'h1);
    chk("rst.rl1.resp",  32'(bus1.resp_valid), 32'h0);
    chk("rst.rl1.data",  bus1.read_data, 32'h0);
    chk("rst.rl1.flags", 32'({bus1.misaligned, bus1.out_of_range, bus1.illegal_size}), 32'h0);
    chk("rst.rl4.ready", 32'(bus4.req_ready), 32'h1);
    chk("rst.rl4.resp",  32'(bus4.resp_valid), 32'h0);
    chk("rst.rl4.data",  bus4.read_data, 32'h0);
    chk("rst.rl4.flags", 32'({bus4.misaligned, bus4.out_of_range, bus4.illegal_size}), 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Fill the two address windows the random phase uses.
    for (int unsigned w = 0; w < 16; w++)
      do_txn(1'b1, 3'b010, 32'(w * 4), $urandom, g1, g4, f4);
    for (int unsigned w = 1020; w < 1024; w++)
      do_txn(1'b1, 3'b010, 32'(w * 4), $urandom, g1, g4, f4);

    // Directed scenarios.
    do_txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, g1, g4, f4);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, g1, g4, f4);
    chk("lw10.rl1", g1, 32'hDEAD_BEEF);
    chk("lw10.rl4", g4, 32'hDEAD_BEEF);
    chk("lw10.flags", 32'(f4), 32'h0);
    do_txn(1'b1, 3'b000, 32'h13, 32'h0000_0080, g1, g4, f4);
    do_txn(1'b0, 3'b000, 32'h13, 32'h0, g1, g4, f4);
    chk("lb13", g4, 32'hFFFF_FF80);
    do_txn(1'b0, 3'b100, 32'h13, 32'h0, g1, g4, f4);
    chk("lbu13", g4, 32'h0000_0080);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, g1, g4, f4);
    chk("lw10.after_sb", g1, 32'h80AD_BEEF);
    do_txn(1'b1, 3'b001, 32'h22, 32'h0000_1234, g1, g4, f4);
    do_txn(1'b0, 3'b001, 32'h22, 32'h0, g1, g4, f4);
    chk("lh22", g4, 32'h0000_1234);
    do_txn(1'b0, 3'b010, 32'h21, 32'h0, g1, g4, f4);
    chk("lw21.flags", 32'(f4), 32'h4);
    chk("lw21.data", g4, 32'h0);
    do_txn(1'b0, 3'b010, 32'h0, 32'h0, g1, g4, f4);
    prior = g4;
    do_txn(1'b1, 3'b010, 32'h1000, 32'hCAFE_F00D, g1, g4, f4);
    chk("sw1000.flags", 32'(f4), 32'h2);
    do_txn(1'b0, 3'b010, 32'h0, 32'h0, g1, g4, f4);
    chk("lw0.unchanged", g4, prior);
    do_txn(1'b0, 3'b011, 32'h0, 32'h0, g1, g4, f4);
    chk("f3_011.flags", 32'(f4), 32'h1);
    do_txn(1'b1, 3'b100, 32'h4, 32'h1111_1111, g1, g4, f4);
    chk("sbu.flags", 32'(f4), 32'h1);

    // Back-to-back requests with req_valid held high.
    model_op(1'b0, 3'b010, 32'h10, 32'h0, erd, efl);
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    address    = 32'h10;
    req_valid  = 1'b1;
    for (int unsigned i = 0; i < 30; i++) begin
      chk("cont.rl4.ready", 32'(bus4.req_ready), 32'(i % 5 == 0));
      chk("cont.rl4.resp",  32'(bus4.resp_valid), 32'(i % 5 == 4));
      chk("cont.rl4.data",  bus4.read_data, (i % 5 == 4) ? erd : 32'h0);
      chk("cont.rl1.ready", 32'(bus1.req_ready), 32'(i % 2 == 0));
      chk("cont.rl1.resp",  32'(bus1.resp_valid), 32'(i % 2 == 1));
      chk("cont.rl1.data",  bus1.read_data, (i % 2 == 1) ? erd : 32'h0);
      if (i == 29) req_valid = 1'b0;
      @(posedge clock); #1;
    end

    // Reset while the latency-4 instance is waiting on a store.
    model_op(1'b1, 3'b010, 32'h30, 32'h5A5A_1234, erd, efl);
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    address    = 32'h30;
    write_data = 32'h5A5A_1234;
    req_valid  = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("rstmid.pre.ready", 32'(bus4.req_ready), 32'h0);
    reset = 1'b1;
    #1;
    chk("rstmid.ready", 32'(bus4.req_ready), 32'h1);
    chk("rstmid.resp",  32'(bus4.resp_valid), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      chk("rstmid.rl4.resp",  32'(bus4.resp_valid), 32'h0);
      chk("rstmid.rl4.ready", 32'(bus4.req_ready), 32'h1);
      chk("rstmid.rl1.resp",  32'(bus1.resp_valid), 32'h0);
      @(posedge clock); #1;
    end
    do_txn(1'b0, 3'b010, 32'h30, 32'h0, g1, g4, f4);
    chk("rstmid.committed", g4, 32'h5A5A_1234);

    // Randomized traffic.
    for (int unsigned t = 0; t < 200; t++) begin
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else                           f3 = f3_tab[$urandom_range(0, 4)];
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'($urandom_range(0, 63));
      else if (sel == 8) a = 32'h0FF0 + 32'($urandom_range(0, 15));
      else               a = $urandom | 32'h0000_1000;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      do_txn(1'($urandom_range(0, 1)), f3, a, $urandom, g1, g4, f4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
